// File: rtl/jogo_memoria_pkg.sv
// Shared types and helpers for the parametrised sequence memory game.
// State codes, LFSR constants and one-hot utilities.
package jogo_memoria_pkg;

  typedef enum logic [4:0] {
    INICIAL  = 5'h00,
    PREPARA  = 5'h01,
    MOSTRA   = 5'h02,
    PAUSA    = 5'h03,
    REARMA   = 5'h04,
    ESPERA   = 5'h05,
    PROXIMO  = 5'h06,
    NIVEL_OK = 5'h07,
    ERRO     = 5'h08,
    GANHOU   = 5'h09,
    PERDEU   = 5'h0A
  } estado_t;

  localparam int          LFSR_W       = 16;
  localparam logic [15:0] LFSR_SEMENTE = 16'hACE1;
  // Taps 16,14,13,11 of the Fibonacci LFSR
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  function automatic logic [15:0] lfsr_prox(
    input logic [15:0] v
  );
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic is_onehot(
    input logic [15:0] v
  );
    return (v != 16'd0) &&
           ((v & (v - 16'd1)) == 16'd0);
  endfunction

  function automatic logic [3:0] onehot_to_idx(
    input logic [15:0] v
  );
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) r = r | 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/gerador_sequencia.sv
// Free-running and replay LFSR pair; the replay LFSR regenerates
// the same sequence from the captured seed for display and checking.
module gerador_sequencia
  import jogo_memoria_pkg::*;
#(
  parameter int IW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          avanca_i,
  input  logic          captura_i,
  input  logic          carrega_i,
  input  logic          passo_i,
  output logic [IW-1:0] idx_o
);

  logic [LFSR_W-1:0] livre_q;
  logic [LFSR_W-1:0] semente_q;
  logic [LFSR_W-1:0] rep_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      livre_q   <= LFSR_SEMENTE;
      semente_q <= LFSR_SEMENTE;
      rep_q     <= LFSR_SEMENTE;
    end else begin
      if (avanca_i)
        livre_q <= lfsr_prox(livre_q);
      if (captura_i)
        semente_q <= livre_q;
      if (carrega_i)
        rep_q <= semente_q;
      else if (passo_i)
        rep_q <= lfsr_prox(rep_q);
    end
  end

  assign idx_o = rep_q[IW-1:0];

endmodule

// File: rtl/jogo_memoria_sequencia_param.sv
// Simon-style sequence game on an N x N LED matrix with timeout and lives.
// Define MODO_TREINO_EN for training mode (errors never cost a life).
module jogo_memoria_sequencia_param
  import jogo_memoria_pkg::*;
#(
  parameter int N_BOTOES = 8,
  parameter int N_NIVEIS = 8,
  parameter int T_MOSTRA = 25_000_000,
  parameter int T_PAUSA  = 12_500_000,
  parameter int T_JOGADA = 150_000_000,
  parameter int N_VIDAS  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] colunas,
  output logic [N_BOTOES-1:0] linhas,
  output logic                ganhou,
  output logic                perdeu,
  output logic [4:0]          db_estado,
  output logic [3:0]          db_nivel,
  output logic [2:0]          db_vidas
);

  localparam int IW = $clog2(N_BOTOES);
  localparam int T_A = (T_MOSTRA > T_PAUSA) ? T_MOSTRA : T_PAUSA;
  localparam int T_MAX = (T_A > T_JOGADA) ? T_A : T_JOGADA;
  localparam int TW = $clog2(T_MAX) + 1;

  typedef logic [TW-1:0] tempo_t;

  localparam tempo_t FIM_MOSTRA = tempo_t'(T_MOSTRA - 1);
  localparam tempo_t FIM_PAUSA  = tempo_t'(T_PAUSA - 1);
  localparam tempo_t FIM_JOGADA = tempo_t'(T_JOGADA - 1);
  localparam logic [3:0] ULTIMO = 4'(N_NIVEIS - 1);
  localparam logic [2:0] VIDAS0 = 3'(N_VIDAS);
  localparam logic [N_BOTOES-1:0] UM =
    {{(N_BOTOES-1){1'b0}}, 1'b1};

  estado_t estado_q, estado_d;
  tempo_t  tempo_q, tempo_d;
  logic [3:0] nivel_q, nivel_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] vidas_q, vidas_d;
  logic       prev_q;
  logic [IW-1:0] varre_q;

  logic [N_BOTOES-1:0] col_d, lin_d;
  logic [N_BOTOES-1:0] colunas_q, linhas_q;
  logic ganhou_q, perdeu_q;
  logic [4:0] db_estado_q;
  logic [3:0] db_nivel_q;
  logic [2:0] db_vidas_q;

  logic avanca, captura, carrega, passo;
  logic [IW-1:0] seq_idx;
  logic [3:0] tecla;
  logic borda, valido;

  gerador_sequencia #(.IW(IW)) u_gerador (
    .clk_i     (clock),
    .rst_ni    (reset),
    .avanca_i  (avanca),
    .captura_i (captura),
    .carrega_i (carrega),
    .passo_i   (passo),
    .idx_o     (seq_idx)
  );

  // Press = rising edge of any button; held buttons never re-trigger
  assign borda  = (|botoes) & ~prev_q;
  assign valido = is_onehot(16'(botoes));
  assign tecla  = onehot_to_idx(16'(botoes));

  always_comb begin
    estado_d = estado_q;
    nivel_d  = nivel_q;
    idx_d    = idx_q;
    vidas_d  = vidas_q;
    tempo_d  = (tempo_q == '1) ? tempo_q
                               : tempo_q + 1'b1;
    avanca   = (estado_q == INICIAL);
    captura  = 1'b0;
    carrega  = 1'b0;
    passo    = 1'b0;
    unique case (estado_q)
      INICIAL: if (jogar) begin
        estado_d = PREPARA;
        captura  = 1'b1;
      end
      PREPARA: begin
        idx_d    = 4'd0;
        carrega  = 1'b1;
        estado_d = MOSTRA;
      end
      MOSTRA: if (tempo_q == FIM_MOSTRA)
        estado_d = PAUSA;
      PAUSA: if (tempo_q == FIM_PAUSA) begin
        if (idx_q == nivel_q) begin
          estado_d = REARMA;
        end else begin
          idx_d    = idx_q + 4'd1;
          passo    = 1'b1;
          estado_d = MOSTRA;
        end
      end
      REARMA: begin
        idx_d    = 4'd0;
        carrega  = 1'b1;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (borda)
          estado_d = (valido && tecla == 4'(seq_idx))
                     ? PROXIMO : ERRO;
        else if (tempo_q == FIM_JOGADA)
          estado_d = ERRO;
      end
      PROXIMO: begin
        if (idx_q == nivel_q) begin
          estado_d = NIVEL_OK;
        end else begin
          idx_d    = idx_q + 4'd1;
          passo    = 1'b1;
          estado_d = ESPERA;
        end
      end
      NIVEL_OK: begin
        if (nivel_q == ULTIMO) begin
          estado_d = GANHOU;
        end else begin
          nivel_d  = nivel_q + 4'd1;
          estado_d = PREPARA;
        end
      end
      ERRO: begin
`ifdef MODO_TREINO_EN
        estado_d = PREPARA;
`else
        vidas_d  = vidas_q - 3'd1;
        estado_d = (vidas_q == 3'd1) ? PERDEU : PREPARA;
`endif
      end
      GANHOU, PERDEU: if (jogar) begin
        estado_d = INICIAL;
        nivel_d  = 4'd0;
        vidas_d  = VIDAS0;
      end
      default: estado_d = INICIAL;
    endcase
    if (estado_d != estado_q)
      tempo_d = '0;
  end

  always_comb begin
    col_d = '0;
    lin_d = '0;
    unique case (estado_q)
      MOSTRA: begin
        col_d = UM << seq_idx;
        lin_d = '1;
      end
      GANHOU: begin
        col_d = '1;
        lin_d = '1;
      end
      // Diagonal is scanned one LED per cycle
      PERDEU: begin
        col_d = UM << varre_q;
        lin_d = UM << varre_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= INICIAL;
      tempo_q     <= '0;
      nivel_q     <= 4'd0;
      idx_q       <= 4'd0;
      vidas_q     <= VIDAS0;
      prev_q      <= 1'b0;
      varre_q     <= '0;
      colunas_q   <= '0;
      linhas_q    <= '0;
      ganhou_q    <= 1'b0;
      perdeu_q    <= 1'b0;
      db_estado_q <= 5'h00;
      db_nivel_q  <= 4'd0;
      db_vidas_q  <= VIDAS0;
    end else begin
      estado_q    <= estado_d;
      tempo_q     <= tempo_d;
      nivel_q     <= nivel_d;
      idx_q       <= idx_d;
      vidas_q     <= vidas_d;
      prev_q      <= |botoes;
      varre_q     <= varre_q + 1'b1;
      colunas_q   <= col_d;
      linhas_q    <= lin_d;
      ganhou_q    <= (estado_q == GANHOU);
      perdeu_q    <= (estado_q == PERDEU);
      db_estado_q <= estado_q;
      db_nivel_q  <= nivel_q;
      db_vidas_q  <= vidas_q;
    end
  end

  assign colunas   = colunas_q;
  assign linhas    = linhas_q;
  assign ganhou    = ganhou_q;
  assign perdeu    = perdeu_q;
  assign db_estado = db_estado_q;
  assign db_nivel  = db_nivel_q;
  assign db_vidas  = db_vidas_q;

endmodule
